// File: rtl/dmem_if.sv
// Processor data-memory port plus the dump stream toward the debug sink.
// The master side is the processor/debug driver; the slave side is the memory.
interface dmem_if #(
    parameter int N  = 64,
    parameter int AW = 6
);
    logic          memWrite;
    logic          memRead;
    logic [AW-1:0] address;
    logic [N-1:0]  writeData;
    logic [N-1:0]  readData;
    logic          dump;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [N-1:0]  dump_data;
    logic          dump_busy;
    logic          dump_done;

    modport master (
        output memWrite, memRead, address, writeData, dump, dump_ready,
        input  readData, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  memWrite, memRead, address, writeData, dump, dump_ready,
        output readData, dump_valid, dump_addr, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-cycle data memory for the MEM stage, with a dump engine that streams
// every word out over valid/ready without ever stalling processor accesses.
module dmem_responder #(
    parameter int N  = 64,
    parameter int AW = 6
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int            DEPTH = 2**AW;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  ddata_q, ddata_d;
    logic          dump_q;
    logic          req;
    logic          load;
    logic [AW-1:0] load_addr;

    assign req = bus.dump & ~dump_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        load      = 1'b0;
        load_addr = ptr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = SCAN;
                    ptr_d     = '0;
                    load      = 1'b1;
                    load_addr = '0;
                end
            end
            SCAN: begin
                if (bus.dump_ready) begin
                    // Last word: finish instead of wrapping the pointer.
                    if (ptr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        ptr_d     = ptr_q + AW'(1);
                        load      = 1'b1;
                        load_addr = ptr_q + AW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A store landing on the word being captured must be seen in the beat.
    always_comb begin
        ddata_d = ddata_q;
        if (load) begin
            if (bus.memWrite && (bus.address == load_addr)) ddata_d = bus.writeData;
            else                                            ddata_d = mem_q[load_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ddata_q <= '0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ddata_q <= ddata_d;
            dump_q  <= bus.dump;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.memWrite) begin
            mem_q[bus.address] <= bus.writeData;
        end
    end

    assign bus.readData   = bus.memRead ? mem_q[bus.address] : '0;
    assign bus.dump_valid = (state_q == SCAN);
    assign bus.dump_busy  = (state_q != IDLE);
    assign bus.dump_done  = (state_q == DONE);
    assign bus.dump_addr  = ptr_q;
    assign bus.dump_data  = ddata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a word-array model
// that tracks memory contents, the current dump beat and beat/done counts.
module tb_dmem_responder;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam int D  = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_if #(.N(N), .AW(AW)) bus ();
    dmem_responder #(.N(N), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [N-1:0]  ref_mem [D];
    int            phase;      // 0 idle, 1 streaming, 2 done pulse
    logic [AW-1:0] m_ptr;
    logic [N-1:0]  m_data;
    bit            m_dprev;
    int            beats, dones;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        phase = 0; m_ptr = '0; m_data = '0; m_dprev = 1'b0;
    endtask

    task automatic check_dump_outs();
        chk("dump_valid", bus.dump_valid, N'(phase == 1));
        chk("dump_busy",  bus.dump_busy,  N'(phase != 0));
        chk("dump_done",  bus.dump_done,  N'(phase == 2));
        chk("dump_addr",  bus.dump_addr,  N'(m_ptr));
        chk("dump_data",  bus.dump_data,  m_data);
    endtask

    // One clock: drive, check combinational/registered outputs, advance model.
    task automatic step(input bit mw, input bit mr, input int a, input logic [N-1:0] wd,
                        input bit dmp, input bit rdy);
        bus.memWrite = mw; bus.memRead = mr; bus.address = AW'(a);
        bus.writeData = wd; bus.dump = dmp; bus.dump_ready = rdy;
        #2;
        chk("readData", bus.readData, mr ? ref_mem[a] : '0);
        check_dump_outs();
        @(posedge clk);
        if (phase == 0) begin
            if (dmp && !m_dprev) begin
                phase = 1; m_ptr = '0;
                m_data = (mw && a == 0) ? wd : ref_mem[0];
            end
        end else if (phase == 1) begin
            if (rdy) begin
                beats++;
                if (m_ptr == AW'(D - 1)) phase = 2;
                else begin
                    m_ptr = m_ptr + 1'b1;
                    m_data = (mw && AW'(a) == m_ptr) ? wd : ref_mem[m_ptr];
                end
            end
        end else begin
            phase = 0; dones++;
        end
        m_dprev = dmp;
        if (mw) ref_mem[a] = wd;
        #1;
    endtask

    task automatic do_reset();
        bus.memWrite = 0; bus.memRead = 0; bus.address = '0; bus.writeData = '0;
        bus.dump = 0; bus.dump_ready = 0;
        reset = 1'b1;
        #1;
        model_clear();
        check_dump_outs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Runs a whole dump from a rising edge; mode 0 ready high, 1 pattern 1-0-0-1, 2 random.
    task automatic run_dump(input int mode, input bit traffic, input string tag);
        int k, b0, d0;
        bit rdy, mw, mr;
        b0 = beats; d0 = dones; k = 0;
        step(0, 0, 0, '0, 0, 0);
        step(0, 0, 0, '0, 1, 0);
        while (phase != 0 && k < 1000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            mw = traffic && ($urandom_range(0, 2) == 0);
            mr = traffic && ($urandom_range(0, 1) == 1);
            step(mw, mr, int'($urandom_range(0, D - 1)), {$urandom, $urandom}, 1, rdy);
            k++;
        end
        chk({tag, "_timeout"}, N'(phase == 0), N'(1));
        chk({tag, "_beats"}, N'(beats - b0), N'(D));
        chk({tag, "_dones"}, N'(dones - d0), N'(1));
        step(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        int k;
        beats = 0; dones = 0;
        model_clear();
        do_reset();

        // Basic read/write, read gating
        step(0, 1, 5, '0, 0, 0);
        chk("rd_after_reset", bus.readData, '0);
        step(1, 0, 5, 64'hDEADBEEF, 0, 0);
        step(0, 1, 5, '0, 0, 0);
        chk("rd_deadbeef", bus.readData, 64'hDEADBEEF);
        step(0, 0, 5, '0, 0, 0);
        chk("rd_gated", bus.readData, '0);

        // Same-cycle read/write returns old data, new data next cycle
        step(1, 0, 9, 64'h22, 0, 0);
        bus.memWrite = 1; bus.memRead = 1; bus.address = 6'd9; bus.writeData = 64'h11;
        #2;
        chk("rw_same_old", bus.readData, 64'h22);
        #1;
        step(1, 1, 9, 64'h11, 0, 0);
        step(0, 1, 9, '0, 0, 0);
        chk("rw_same_new", bus.readData, 64'h11);

        // Preload i*3 and stream with ready high: one beat per cycle
        for (int i = 0; i < D; i++) step(1, 0, i, N'(i * 3), 0, 0);
        step(0, 0, 0, '0, 0, 0);
        step(0, 0, 0, '0, 1, 1);
        chk("first_valid", bus.dump_valid, N'(1));
        chk("first_data", bus.dump_data, '0);
        k = 0;
        while (phase == 1 && k < 100) begin step(0, 0, 0, '0, 1, 1); k++; end
        chk("full_cycles", N'(k), N'(D));
        chk("done_pulse", bus.dump_done, N'(1));
        chk("last_data", bus.dump_data, N'(189));
        step(0, 0, 0, '0, 1, 1);
        chk("busy_low_after", bus.dump_busy, '0);

        run_dump(1, 0, "toggle");

        // Hold at word 7 while it is overwritten; bypass into word 8
        step(0, 0, 0, '0, 1, 0);
        k = 0;
        while (m_ptr != AW'(7) && k < 20) begin step(0, 0, 0, '0, 1, 1); k++; end
        chk("hold_reach7", bus.dump_addr, N'(7));
        step(1, 0, 7, 64'hAA, 1, 0);
        chk("hold_data7", bus.dump_data, N'(21));
        step(1, 0, 8, 64'hBB, 1, 1);
        chk("bypass_addr8", bus.dump_addr, N'(8));
        chk("bypass_data8", bus.dump_data, 64'hBB);
        k = 0;
        while (phase != 0 && k < 100) begin step(0, 0, 0, '0, 1, 1); k++; end
        chk("hold_finish", N'(phase), '0);

        run_dump(2, 1, "random");
        run_dump(2, 1, "random2");

        // Reset in the middle of a dump aborts it silently
        for (int i = 0; i < 8; i++) step(1, 0, i, {$urandom, $urandom}, 0, 0);
        step(0, 0, 0, '0, 1, 1);
        k = beats;
        while (beats - k < 20 && phase == 1) step(0, 0, 0, '0, 1, 1);
        k = dones;
        do_reset();
        chk("rst_valid", bus.dump_valid, '0);
        chk("rst_busy", bus.dump_busy, '0);
        for (int i = 0; i < 8; i++) step(0, 1, i, '0, 0, 0);
        chk("rst_no_done", N'(dones - k), '0);

        // Dump held high afterwards must not retrigger
        step(0, 0, 0, '0, 1, 1);
        chk("restart_addr0", bus.dump_addr, '0);
        k = 0;
        while (phase != 0 && k < 100) begin step(0, 0, 0, '0, 1, 1); k++; end
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1, 1);
        chk("no_retrigger", bus.dump_busy, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
